// File: rtl/checker_memory_ctrl_if.sv
// Request/ack signals for both requesters plus the port A connection to the checker byte memory.
interface checker_memory_ctrl_if #(
   parameter int AW = 11
);
   logic          r0_req;
   logic          r0_we;
   logic [3:0]    r0_sel;
   logic [AW-1:0] r0_adr;
   logic [31:0]   r0_dat_w;
   logic          r0_ack;
   logic          r0_err;

   logic          r1_req;
   logic          r1_we;
   logic [3:0]    r1_sel;
   logic [AW-1:0] r1_adr;
   logic [31:0]   r1_dat_w;
   logic          r1_ack;
   logic          r1_err;

   logic [31:0]   rd_dat;
   logic [15:0]   mem_addr;
   logic [3:0]    mem_we;
   logic [31:0]   mem_di;
   logic [31:0]   mem_do;

   modport master (
      output r0_req, r0_we, r0_sel, r0_adr, r0_dat_w,
      output r1_req, r1_we, r1_sel, r1_adr, r1_dat_w,
      input  r0_ack, r0_err, r1_ack, r1_err, rd_dat,
      input  mem_addr, mem_we, mem_di,
      output mem_do
   );

   modport slave (
      input  r0_req, r0_we, r0_sel, r0_adr, r0_dat_w,
      input  r1_req, r1_we, r1_sel, r1_adr, r1_dat_w,
      output r0_ack, r0_err, r1_ack, r1_err, rd_dat,
      output mem_addr, mem_we, mem_di,
      input  mem_do
   );
endinterface

// File: rtl/checker_memory_ctrl.sv
// Round-robin sharing of checker memory port A between r0 and r1; writes split into one-hot byte writes.
// Read ack at cycle 3, write ack at cycle n+1 (n in-range lanes); loser waits with req held.
module checker_memory_ctrl #(
   parameter int AW   = 11,
   parameter int MAXB = 2047
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   checker_memory_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, RADDR, RCAPT, WRITE, DONE} state_t;

   state_t      state;
   logic        last;
   logic        owner;
   logic [3:0]  pending;
   logic [3:0]  range_l;
   logic        err_l;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rd;
   logic [15:0] maddr;
   logic [3:0]  mwe;
   logic [31:0] mdi;

   // Lane k is usable when byte adr+k still exists in the memory.
   function automatic logic [3:0] lanes_ok(input logic [AW-1:0] a);
      logic [AW:0] b;
      lanes_ok = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         b = {1'b0, a} + (AW+1)'(k);
         lanes_ok[k] = (b <= (AW+1)'(MAXB));
      end
   endfunction

   function automatic logic [3:0] lowest(input logic [3:0] m);
      return m & (~m + 4'd1);
   endfunction

   logic          gnt;
   logic          g_we;
   logic [3:0]    g_sel;
   logic [AW-1:0] g_adr;
   logic [31:0]   g_dat;
   logic [3:0]    g_rng;
   logic [3:0]    g_mask;
   logic          g_err;

   // r0 wins unless r1 alone is asking or r0 owned the previous transaction.
   assign gnt    = !(bus.r0_req && (!bus.r1_req || last));
   assign g_we   = gnt ? bus.r1_we    : bus.r0_we;
   assign g_sel  = gnt ? bus.r1_sel   : bus.r0_sel;
   assign g_adr  = gnt ? bus.r1_adr   : bus.r0_adr;
   assign g_dat  = gnt ? bus.r1_dat_w : bus.r0_dat_w;
   assign g_rng  = lanes_ok(g_adr);
   assign g_mask = g_sel & g_rng;
   assign g_err  = |(g_sel & ~g_rng);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         last    <= 1'b1;
         owner   <= 1'b0;
         pending <= 4'b0000;
         range_l <= 4'b0000;
         err_l   <= 1'b0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         rd      <= 32'h0;
         maddr   <= 16'h0;
         mwe     <= 4'b0000;
         mdi     <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               mwe <= 4'b0000;
               if (bus.r0_req || bus.r1_req) begin
                  owner   <= gnt;
                  last    <= gnt;
                  maddr   <= {{(13-AW){1'b0}}, g_adr, 3'b000};
                  mdi     <= g_dat;
                  err_l   <= g_err;
                  range_l <= g_rng;
                  if (!g_we) begin
                     state <= RADDR;
                  end else if (g_mask != 4'b0000) begin
                     mwe     <= lowest(g_mask);
                     pending <= g_mask & ~lowest(g_mask);
                     state   <= WRITE;
                  end else begin
                     ack0  <= !gnt;
                     ack1  <= gnt;
                     err0  <= !gnt && g_err;
                     err1  <= gnt && g_err;
                     state <= DONE;
                  end
               end
            end
            RADDR: begin
               mwe   <= 4'b0000;
               state <= RCAPT;
            end
            RCAPT: begin
               rd    <= bus.mem_do & {{8{range_l[3]}}, {8{range_l[2]}},
                                      {8{range_l[1]}}, {8{range_l[0]}}};
               ack0  <= !owner;
               ack1  <= owner;
               err0  <= !owner && err_l;
               err1  <= owner && err_l;
               state <= DONE;
            end
            WRITE: begin
               if (pending != 4'b0000) begin
                  mwe     <= lowest(pending);
                  pending <= pending & ~lowest(pending);
               end else begin
                  mwe   <= 4'b0000;
                  ack0  <= !owner;
                  ack1  <= owner;
                  err0  <= !owner && err_l;
                  err1  <= owner && err_l;
                  state <= DONE;
               end
            end
            DONE: begin
               mwe   <= 4'b0000;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.r0_ack   = ack0;
   assign bus.r1_ack   = ack1;
   assign bus.r0_err   = err0;
   assign bus.r1_err   = err1;
   assign bus.rd_dat   = rd;
   assign bus.mem_addr = maddr;
   assign bus.mem_we   = mwe;
   assign bus.mem_di   = mdi;
endmodule

// File: tb/tb_checker_memory_ctrl.sv
// Directed bench: byte memory model on port A, vector table of single transactions, plus tie and reset sequences.
module tb_checker_memory_ctrl;
   logic sys_clk = 1'b0;
   logic sys_rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   checker_memory_ctrl_if #(.AW(11)) bus ();

   checker_memory_ctrl #(.AW(11), .MAXB(2047)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   // Port A model: registered read, one-hot byte write at index + lane.
   logic [7:0] mem [0:2047] = '{default: 8'h00};
   function automatic logic [7:0] rb(input int a);
      return (a <= 2047) ? mem[a] : 8'h00;
   endfunction
   always @(posedge sys_clk) begin
      int idx;
      idx = int'(bus.mem_addr[14:3]);
      for (int k = 0; k < 4; k++)
         if (bus.mem_we[k] && (idx + k) <= 2047) mem[idx + k] <= bus.mem_di[8*k +: 8];
      bus.mem_do <= {rb(idx + 3), rb(idx + 2), rb(idx + 1), rb(idx)};
   end

   typedef struct {
      logic        who;
      logic        we;
      logic [3:0]  sel;
      logic [10:0] adr;
      logic [31:0] dat;
      int          lat;
      logic        err;
      logic [31:0] rd;
      logic [15:0] weseq;
   } vec_t;
   vec_t tbl [13];

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v, output int lat, output logic err, output logic [31:0] rd,
                          output logic [15:0] weseq, output logic [15:0] addr1, output logic other);
      int n;
      lat = -1; err = 0; rd = 0; weseq = 0; addr1 = 0; other = 0; n = 0;
      if (!v.who) begin
         bus.r0_we = v.we; bus.r0_sel = v.sel; bus.r0_adr = v.adr; bus.r0_dat_w = v.dat; bus.r0_req = 1'b1;
      end else begin
         bus.r1_we = v.we; bus.r1_sel = v.sel; bus.r1_adr = v.adr; bus.r1_dat_w = v.dat; bus.r1_req = 1'b1;
      end
      for (int c = 1; c <= 20; c++) begin
         tick;
         if (c == 1) addr1 = bus.mem_addr;
         if (bus.mem_we != 4'b0000 && n < 4) begin
            weseq = weseq | (16'(bus.mem_we) << (4 * n));
            n++;
         end
         if (v.who ? bus.r1_ack : bus.r0_ack) begin
            lat   = c;
            err   = v.who ? bus.r1_err : bus.r0_err;
            rd    = bus.rd_dat;
            other = v.who ? bus.r0_ack : bus.r1_ack;
            break;
         end
      end
      bus.r0_req = 1'b0;
      bus.r1_req = 1'b0;
      tick;
   endtask

   initial begin
      int          lat, cnt, first;
      logic        err, other;
      logic [31:0] rd;
      logic [15:0] weseq, addr1;

      tbl[0]  = '{1'b0, 1'b1, 4'hF, 11'h010, 32'hA1B2C3D4, 5, 1'b0, 32'h0,        16'h8421};
      tbl[1]  = '{1'b0, 1'b0, 4'hF, 11'h010, 32'h0,        3, 1'b0, 32'hA1B2C3D4, 16'h0};
      tbl[2]  = '{1'b1, 1'b1, 4'h5, 11'h020, 32'h11223344, 3, 1'b0, 32'h0,        16'h0041};
      tbl[3]  = '{1'b1, 1'b0, 4'hF, 11'h020, 32'h0,        3, 1'b0, 32'h00220044, 16'h0};
      tbl[4]  = '{1'b0, 1'b1, 4'hF, 11'h7FE, 32'hDEADBEEF, 3, 1'b1, 32'h0,        16'h0021};
      tbl[5]  = '{1'b0, 1'b0, 4'hF, 11'h7FE, 32'h0,        3, 1'b1, 32'h0000BEEF, 16'h0};
      tbl[6]  = '{1'b0, 1'b1, 4'h0, 11'h100, 32'h12345678, 1, 1'b0, 32'h0,        16'h0};
      tbl[7]  = '{1'b1, 1'b1, 4'hE, 11'h7FF, 32'hFFFFFFFF, 1, 1'b1, 32'h0,        16'h0};
      tbl[8]  = '{1'b0, 1'b1, 4'h3, 11'h7FF, 32'h000055AA, 2, 1'b1, 32'h0,        16'h0001};
      tbl[9]  = '{1'b1, 1'b0, 4'hF, 11'h7FC, 32'h0,        3, 1'b0, 32'hAAEF0000, 16'h0};
      tbl[10] = '{1'b0, 1'b0, 4'h1, 11'h7FF, 32'h0,        3, 1'b0, 32'h000000AA, 16'h0};
      tbl[11] = '{1'b0, 1'b1, 4'h8, 11'h013, 32'h77000000, 2, 1'b0, 32'h0,        16'h0008};
      tbl[12] = '{1'b0, 1'b0, 4'hF, 11'h014, 32'h0,        3, 1'b0, 32'h00770000, 16'h0};

      sys_rst_n = 1'b0;
      bus.r0_req = 0; bus.r0_we = 0; bus.r0_sel = 0; bus.r0_adr = 0; bus.r0_dat_w = 0;
      bus.r1_req = 0; bus.r1_we = 0; bus.r1_sel = 0; bus.r1_adr = 0; bus.r1_dat_w = 0;
      repeat (2) tick;
      chk("rst_mem_we",   32'(bus.mem_we),   32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_di",   bus.mem_di,        32'h0);
      chk("rst_acks",     32'({bus.r0_ack, bus.r1_ack}), 32'h0);
      chk("rst_errs",     32'({bus.r0_err, bus.r1_err}), 32'h0);
      chk("rst_rd_dat",   bus.rd_dat,        32'h0);
      sys_rst_n = 1'b1;
      tick;

      // Both requesters read continuously: grants alternate starting with r0.
      bus.r0_sel = 4'hF; bus.r0_adr = 11'h010; bus.r1_sel = 4'hF; bus.r1_adr = 11'h010;
      bus.r0_req = 1'b1; bus.r1_req = 1'b1;
      cnt = 0;
      for (int c = 0; c < 60 && cnt < 6; c++) begin
         tick;
         chk("rr_dual_ack", 32'(bus.r0_ack & bus.r1_ack), 32'h0);
         if (bus.r0_ack || bus.r1_ack) begin
            chk($sformatf("rr_order_%0d", cnt), 32'(bus.r1_ack), 32'(cnt % 2));
            cnt++;
         end
      end
      chk("rr_count", 32'(cnt), 32'd6);
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      repeat (2) tick;

      for (int i = 0; i < 13; i++) begin
         run_txn(tbl[i], lat, err, rd, weseq, addr1, other);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("v%0d_err", i),     32'(err), 32'(tbl[i].err));
         chk($sformatf("v%0d_other_ack", i), 32'(other), 32'h0);
         chk($sformatf("v%0d_mem_addr", i), 32'(addr1), 32'({tbl[i].adr, 3'b000}));
         if (tbl[i].we) chk($sformatf("v%0d_we_seq", i), 32'(weseq), 32'(tbl[i].weseq));
         else           chk($sformatf("v%0d_rd_dat", i), bus.rd_dat, tbl[i].rd);
      end

      // Reset in the middle of a 4-lane write drops it without an ack.
      bus.r0_we = 1'b1; bus.r0_sel = 4'hF; bus.r0_adr = 11'h040; bus.r0_dat_w = 32'h55667788;
      bus.r0_req = 1'b1;
      tick;
      tick;
      chk("rst_mid_pre_we", 32'(bus.mem_we), 32'h2);
      sys_rst_n = 1'b0;
      #1;
      chk("rst_mid_we",   32'(bus.mem_we),   32'h0);
      chk("rst_mid_addr", 32'(bus.mem_addr), 32'h0);
      bus.r0_we = 1'b0; bus.r0_adr = 11'h010;
      bus.r1_we = 1'b0; bus.r1_sel = 4'hF; bus.r1_adr = 11'h020; bus.r1_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("rst_mid_no_ack", 32'({bus.r0_ack, bus.r1_ack}), 32'h0);
      end
      chk("rst_mid_lane1_unwritten", 32'(mem[11'h041]), 32'h0);
      sys_rst_n = 1'b1;
      first = -1;
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (bus.r0_ack || bus.r1_ack) begin
            first = c;
            chk("post_rst_winner_r0", 32'({bus.r0_ack, bus.r1_ack}), 32'h2);
            chk("post_rst_rd_dat", bus.rd_dat, 32'hA1B2C3D4);
            break;
         end
      end
      chk("post_rst_latency", 32'(first), 32'd3);
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      repeat (2) tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
